lsu: RTL and testbench
======================

# lsu

Load/store unit: the CPU-side initiator for the single-port, word-organised data memory. It accepts one RV32I load or store request at a time and sign- or zero-extends loaded bytes and halfwords. Because the memory has only a whole-word write enable, byte and halfword stores are done as read-modify-write. The unit sits between the execute stage and the data memory. The memory's read data is combinational from its address; writes take effect on the clock edge.

## Interface
Parameters:
- DEPTH, default 2048: memory size in bytes. AW = $clog2(DEPTH) is the memory address width.

Ports:
- clk  in  1  clock; rising edge only.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high exactly in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address; bits above AW-1 are ignored.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; qualified by rsp_valid.
- mem_addr  out  AW  memory byte address; the memory uses bits [AW-1:2].
- mem_sdata  out  32  memory write data.
- mem_wren  out  1  memory write enable.
- mem_ldata  in  32  memory read data; combinational from mem_addr.

## Operation
States: IDLE, LOAD, READ, WRITE, RESP.

- **IDLE**
  - A request is accepted on any edge where req_valid && req_ready.
  - On accept, latch we, funct3, addr[AW-1:0] and wdata.
  - Illegal funct3 goes to RESP with err=1. Stores accept only 000/001/010; loads accept 000/001/010/100/101.
  - Misaligned access is handled per Configuration.
  - Otherwise: load → LOAD; SW → WRITE, with merge register = wdata; SB/SH → READ.
- **LOAD**
  - Extract the lane from mem_ldata (little-endian; lane = addr[1:0] for B, addr[1] for H).
  - Extend: B/H sign-extend; BU/HU zero-extend; W passes through.
  - Register the result into rsp_rdata, then go to RESP.
- **READ**
  - Merge register = mem_ldata with the addressed byte or half lane replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- **WRITE**
  - mem_wren=1 and mem_sdata = merge register, for exactly this one cycle.
  - Go to RESP.
- **RESP**
  - rsp_valid=1 for one cycle, then go to IDLE.
  - There is no response back-pressure; the consumer must sample it.
- **Memory outputs**
  - mem_addr holds the latched address from accept until the next accept.
  - mem_wren is 0 in every state other than WRITE.
  - A memory access never occurs for an errored request.

## Timing
Accept edge = cycle N. rsp_valid is high in:
- cycle N+2 for loads;
- cycle N+2 for SW;
- cycle N+3 for SB/SH;
- cycle N+1 for errors.

Other timing rules:
- Back-to-back requests: the next accept can occur in the cycle after RESP. Throughput is one request per 3 cycles (loads, SW) or 4 cycles (SB/SH).
- Reset values:
  - state = IDLE, so req_ready=1; requests are not accepted while rst_n is low.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_wren=0, mem_addr=0, mem_sdata=0.
- Reset mid-operation:
  - rst_n low forces IDLE asynchronously.
  - mem_wren drops within the same cycle; no write completes if rst_n is low at the WRITE edge.
  - The pending request is dropped without a response.

## Configuration
- **LSU_MISALIGN_CHECK_EN defined**
  - H/HU with addr[0]=1, or W with addr[1:0]≠0, is rejected.
  - Response in N+1 with rsp_err=1 and rsp_rdata=0; no memory access.
- **Not defined**
  - The unaligned low bits are forced to zero: addr[0] for halfwords, addr[1:0] for words.
  - The access proceeds normally.
  - rsp_err is raised only for illegal funct3.

## Test plan
- Preload word 0x20 = 0x80FF7F01, then:
  - LB 0x22 → rsp_rdata 0xFFFFFFFF;
  - LBU 0x22 → 0x000000FF;
  - LH 0x22 → 0xFFFF80FF;
  - LHU 0x20 → 0x00007F01.
  - Each response arrives at N+2.
- SB 0x21, wdata 0x123456AB → exactly one mem_wren pulse at N+2 with mem_sdata 0x80FFAB01; rsp_valid at N+3; a subsequent LW 0x20 returns 0x80FFAB01.
- SW 0x24 with 0xDEADBEEF, then SH 0x26 with 0x0000CAFE → LW 0x24 returns 0xCAFEBEEF; mem_wren is never high outside WRITE.
- LW 0x22:
  - with LSU_MISALIGN_CHECK_EN → rsp_err=1 at N+1, rsp_rdata 0, no mem_wren;
  - without it → rsp_err=0, rsp_rdata = the word at 0x20.
- Store with funct3 100 → rsp_err=1 at N+1; memory unchanged.
- Assert rst_n low during WRITE of SB 0x20 → mem_wren falls immediately, no rsp_valid, the word is unchanged, and req_ready=1 after release.

Source files
------------

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// master = CPU/memory side, slave = lsu.
interface lsu_if #(
   parameter int unsigned AW = 11
) ();
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_sdata;
   logic          mem_wren;
   logic [31:0]   mem_ldata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ldata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_sdata, mem_wren
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ldata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_sdata, mem_wren
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit for a word-wide memory; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned H/HU/W instead of aligning down.
module lsu #(
   parameter int unsigned DEPTH = 2048
) (
   input logic   clk,
   input logic   rst_n,
   lsu_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

   state_t        state, nxt;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   merge_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          legal, err_in;
   logic [AW-1:0] addr_in;
   logic [31:0]   lane_b, lane_h, ld_ext, merged;

   always_comb begin
      if (bus.req_we)
         legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010);
      else
         legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                 (bus.req_funct3 == 3'b101);
      addr_in = bus.req_addr[AW-1:0];
`ifdef LSU_MISALIGN_CHECK_EN
      err_in = !legal ||
               ((bus.req_funct3[1:0] == 2'b01) && addr_in[0]) ||
               ((bus.req_funct3 == 3'b010) && (addr_in[1:0] != 2'b00));
`else
      err_in = !legal;
      if (bus.req_funct3[1:0] == 2'b01) addr_in[0] = 1'b0;
      if (bus.req_funct3 == 3'b010) addr_in[1:0] = 2'b00;
`endif
   end

   // Little-endian lane extraction and sub-word merge, both keyed off the latched address.
   always_comb begin
      lane_b = bus.mem_ldata >> {addr_q[1:0], 3'b000};
      lane_h = bus.mem_ldata >> {addr_q[1], 4'b0000};
      case (f3_q)
         3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b[7:0]};
         3'b100:  ld_ext = {24'h0, lane_b[7:0]};
         3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h[15:0]};
         3'b101:  ld_ext = {16'h0, lane_h[15:0]};
         default: ld_ext = bus.mem_ldata;
      endcase
      merged = bus.mem_ldata;
      if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (bus.req_valid) begin
               we_q    <= bus.req_we;
               f3_q    <= bus.req_funct3;
               addr_q  <= addr_in;
               wdata_q <= bus.req_wdata;
               merge_q <= bus.req_wdata;
               rdata_q <= '0;
               err_q   <= err_in;
            end
            LOAD:    rdata_q <= ld_ext;
            READ:    merge_q <= merged;
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt           = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.mem_wren  = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (err_in)                       nxt = RESP;
               else if (!bus.req_we)             nxt = LOAD;
               else if (bus.req_funct3 == 3'b010) nxt = WRITE;
               else                              nxt = READ;
            end
         end
         LOAD:  nxt = RESP;
         READ:  nxt = WRITE;
         WRITE: begin
            bus.mem_wren = 1'b1;
            nxt          = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            nxt           = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_sdata = merge_q;

   logic unused_ok;
   assign unused_ok = we_q;
endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a small word-organised memory model.
module tb_lsu;
   localparam int unsigned AW = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   lsu_if #(.AW(AW)) bus ();

   lsu #(.DEPTH(2048)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:511];
   assign bus.mem_ldata = mem[bus.mem_addr[AW-1:2]];
   always @(posedge clk) if (bus.mem_wren) mem[bus.mem_addr[AW-1:2]] <= bus.mem_sdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request; report response latency in cycles after the accept edge (0 = none).
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int wcnt, output logic [31:0] sd);
      @(negedge clk);
      chk("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0; wcnt = 0; sd = '0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.mem_wren) begin
            wcnt++;
            sd = bus.mem_sdata;
         end
         if (bus.rsp_valid) begin
            lat = k;
            rd  = bus.rsp_rdata;
            er  = bus.rsp_err;
            break;
         end
      end
   endtask

   int          lat, wcnt;
   logic [31:0] rd, sd;
   logic        er;

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      #12;
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_err",   bus.rsp_err, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_mem_wren",  bus.mem_wren, 1'b0);
      chk("rst_mem_addr",  {21'h0, bus.mem_addr}, 32'h0);
      chk("rst_mem_sdata", bus.mem_sdata, 32'h0);
      #10 rst_n = 1'b1;

      // Preload 0x20 through a word store
      issue(1'b1, 3'b010, 32'h20, 32'h80FF7F01, lat, rd, er, wcnt, sd);
      chk("sw20_lat", lat, 2);  chk("sw20_wcnt", wcnt, 1);  chk("sw20_sdata", sd, 32'h80FF7F01);
      chk("sw20_err", er, 1'b0); chk("sw20_rdata", rd, 32'h0);

      issue(1'b0, 3'b000, 32'h22, 32'h0, lat, rd, er, wcnt, sd);
      chk("lb22_lat", lat, 2);  chk("lb22_rdata", rd, 32'hFFFFFFFF); chk("lb22_wcnt", wcnt, 0);
      issue(1'b0, 3'b100, 32'h22, 32'h0, lat, rd, er, wcnt, sd);
      chk("lbu22_lat", lat, 2); chk("lbu22_rdata", rd, 32'h000000FF);
      issue(1'b0, 3'b001, 32'h22, 32'h0, lat, rd, er, wcnt, sd);
      chk("lh22_lat", lat, 2);  chk("lh22_rdata", rd, 32'hFFFF80FF);
      issue(1'b0, 3'b101, 32'h20, 32'h0, lat, rd, er, wcnt, sd);
      chk("lhu20_lat", lat, 2); chk("lhu20_rdata", rd, 32'h00007F01); chk("lhu20_err", er, 1'b0);
      issue(1'b0, 3'b000, 32'h21, 32'h0, lat, rd, er, wcnt, sd);
      chk("lb21_rdata", rd, 32'h0000007F);

      issue(1'b1, 3'b000, 32'h21, 32'h123456AB, lat, rd, er, wcnt, sd);
      chk("sb21_lat", lat, 3);  chk("sb21_wcnt", wcnt, 1);  chk("sb21_sdata", sd, 32'h80FFAB01);
      chk("sb21_rdata", rd, 32'h0);
      issue(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, wcnt, sd);
      chk("lw20_lat", lat, 2);  chk("lw20_rdata", rd, 32'h80FFAB01);

      issue(1'b1, 3'b010, 32'h24, 32'hDEADBEEF, lat, rd, er, wcnt, sd);
      chk("sw24_wcnt", wcnt, 1);
      issue(1'b1, 3'b001, 32'h26, 32'h0000CAFE, lat, rd, er, wcnt, sd);
      chk("sh26_lat", lat, 3);  chk("sh26_wcnt", wcnt, 1);  chk("sh26_sdata", sd, 32'hCAFEBEEF);
      issue(1'b0, 3'b010, 32'h24, 32'h0, lat, rd, er, wcnt, sd);
      chk("lw24_rdata", rd, 32'hCAFEBEEF);

      issue(1'b0, 3'b010, 32'h22, 32'h0, lat, rd, er, wcnt, sd);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("lw22_lat", lat, 1);  chk("lw22_err", er, 1'b1);  chk("lw22_rdata", rd, 32'h0);
`else
      chk("lw22_lat", lat, 2);  chk("lw22_err", er, 1'b0);  chk("lw22_rdata", rd, 32'h80FFAB01);
`endif
      chk("lw22_wcnt", wcnt, 0);

      issue(1'b1, 3'b100, 32'h20, 32'h11111111, lat, rd, er, wcnt, sd);
      chk("st100_lat", lat, 1); chk("st100_err", er, 1'b1); chk("st100_wcnt", wcnt, 0);
      chk("st100_rdata", rd, 32'h0);
      issue(1'b0, 3'b011, 32'h20, 32'h0, lat, rd, er, wcnt, sd);
      chk("ld011_lat", lat, 1); chk("ld011_err", er, 1'b1);
      issue(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, wcnt, sd);
      chk("lw20_after_err", rd, 32'h80FFAB01); chk("lw20_after_err_e", er, 1'b0);

      // Reset during the WRITE cycle of SB 0x20
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'h00000055;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstw_wren_before", bus.mem_wren, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rstw_wren_drop", bus.mem_wren, 1'b0);
      chk("rstw_rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstw_ready", bus.req_ready, 1'b1);
      @(negedge clk);
      chk("rstw_no_rsp", bus.rsp_valid, 1'b0);
      issue(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, wcnt, sd);
      chk("rstw_word", rd, 32'h80FFAB01); chk("rstw_word_lat", lat, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
